// File: rtl/pwm_fade_ctrl_pkg.sv
// Shared definitions for the fade controller: FSM states and default widths.
package pwm_fade_ctrl_pkg;

  localparam int PD_CNT_DEF = 8;
  localparam int DIV_W_DEF  = 16;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RAMP_UP = 3'd1,
    RAMP_DN = 3'd2,
    BRTH_UP = 3'd3,
    BRTH_DN = 3'd4
  } fade_state_e;

  // Pick the ramp state heading toward a target; IDLE when already there.
  function automatic fade_state_e ramp_state(input logic up, input logic dn);
    if (up)      return RAMP_UP;
    else if (dn) return RAMP_DN;
    else         return IDLE;
  endfunction

endpackage

// File: rtl/pwm_fade_ctrl_tick_gen.sv
// Step prescaler: counts 0..div and ticks on the last count. div is used live,
// so shrinking it below the running count ticks on the very next cycle.
module tick_gen #(
  parameter int DIV_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic [DIV_W-1:0] div,
  output logic             tick
);

  localparam logic [DIV_W-1:0] ONE = DIV_W'(1);

  logic [DIV_W-1:0] cnt;

  assign tick = (cnt >= div);

  // Free-running count; reload on tick, restart on clr (target accepted).
  always_ff @(posedge clk or posedge rst) begin
    if (rst)              cnt <= '0;
    else if (clr || tick) cnt <= '0;
    else                  cnt <= cnt + ONE;
  end

endmodule

// File: rtl/pwm_fade_ctrl.sv
// Fade controller: ramps duty_cnt one LSB per prescaler tick toward an
// accepted target, or breathes between 0 and the target while brth_en is high.
module pwm_fade_ctrl
  import pwm_fade_ctrl_pkg::*;
#(
  parameter int PD_CNT = PD_CNT_DEF,
  parameter int DIV_W  = DIV_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              tgt_valid,
  input  logic [PD_CNT-1:0] tgt_duty,
  output logic              tgt_ready,
  input  logic [DIV_W-1:0]  step_div,
  input  logic              brth_en,
  output logic [PD_CNT-1:0] duty_cnt,
  output logic              busy,
  output logic              done,
  output logic              brth_wrap
);

  localparam logic [PD_CNT-1:0] ONE  = PD_CNT'(1);
  localparam logic [PD_CNT-1:0] DMAX = {PD_CNT{1'b1}};

  fade_state_e       state, state_n;
  logic [PD_CNT-1:0] target_q, target_n, duty_n, duty_inc, duty_dec;
  logic              done_n, wrap_n, accept, tick;

  assign accept   = tgt_valid & tgt_ready;
  // Saturating neighbours so duty never wraps at either end.
  assign duty_inc = (duty_cnt == DMAX) ? duty_cnt : duty_cnt + ONE;
  assign duty_dec = (duty_cnt == '0)   ? duty_cnt : duty_cnt - ONE;

  tick_gen #(.DIV_W(DIV_W)) u_tick (
    .clk  (clk),
    .rst  (rst),
    .clr  (accept),
    .div  (step_div),
    .tick (tick)
  );

  // Next-state / next-duty decode; an accept overrides any step this cycle.
  always_comb begin
    state_n  = state;
    duty_n   = duty_cnt;
    target_n = target_q;
    done_n   = 1'b0;
    wrap_n   = 1'b0;
    if (accept) begin
      target_n = tgt_duty;
      state_n  = ramp_state(tgt_duty > duty_cnt, tgt_duty < duty_cnt);
      done_n   = (tgt_duty == duty_cnt);
    end else begin
      case (state)
        IDLE: begin
          if (brth_en) state_n = (duty_cnt > target_q) ? BRTH_DN : BRTH_UP;
        end
        RAMP_UP: begin
          if (tick) begin
            duty_n = duty_inc;
            if (duty_inc == target_q) begin
              state_n = IDLE;
              done_n  = 1'b1;
            end
          end
        end
        RAMP_DN: begin
          if (tick) begin
            duty_n = duty_dec;
            if (duty_dec == target_q) begin
              state_n = IDLE;
              done_n  = 1'b1;
            end
          end
        end
        BRTH_UP: begin
          if (!brth_en) begin
            state_n = ramp_state(target_q > duty_cnt, target_q < duty_cnt);
            done_n  = (target_q == duty_cnt);
          end else if (tick) begin
            // At (or above) the top: turn around without stepping past it.
            if (duty_cnt < target_q) begin
              duty_n = duty_inc;
              if (duty_inc == target_q) state_n = BRTH_DN;
            end else begin
              state_n = BRTH_DN;
            end
          end
        end
        BRTH_DN: begin
          if (!brth_en) begin
            state_n = ramp_state(target_q > duty_cnt, target_q < duty_cnt);
            done_n  = (target_q == duty_cnt);
          end else if (tick) begin
            // A zero target parks here at 0 with no wrap pulses.
            if (duty_cnt != '0) begin
              duty_n = duty_dec;
              if (duty_dec == '0 && target_q != '0) begin
                state_n = BRTH_UP;
                wrap_n  = 1'b1;
              end
            end else if (target_q != '0) begin
              state_n = BRTH_UP;
            end
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

  // State, duty and registered status outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      duty_cnt  <= '0;
      target_q  <= '0;
      tgt_ready <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      brth_wrap <= 1'b0;
    end else begin
      state     <= state_n;
      duty_cnt  <= duty_n;
      target_q  <= target_n;
      tgt_ready <= ~brth_en;
      busy      <= (state_n != IDLE);
      done      <= done_n;
      brth_wrap <= wrap_n;
    end
  end

endmodule
